// File: rtl/red_accum_if.sv
// red_accum_if: start/operand, memory read port and RED unit signals of the reduction sequencer.
interface red_accum_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_pairs;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic [15:0]       mem_rdata;
  logic [15:0]       red_a;
  logic [15:0]       red_b;
  logic [15:0]       red_sum;
  logic              busy;
  logic              done;
  logic [15:0]       result;
  logic              ovfl;
  modport master (
    output start, base_addr, num_pairs, mem_rdata, red_sum,
    input  mem_addr, mem_ren, red_a, red_b, busy, done, result, ovfl
  );
  modport slave (
    input  start, base_addr, num_pairs, mem_rdata, red_sum,
    output mem_addr, mem_ren, red_a, red_b, busy, done, result, ovfl
  );
endinterface

// File: rtl/red_accum_ctrl.sv
// red_accum_ctrl: fetches word pairs, feeds the RED unit and accumulates its results with signed saturation.
module red_accum_ctrl #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input logic       clk,
  input logic       rst,
  red_accum_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, ACC, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;
  logic [15:0]       acc;
  logic [16:0]       sum;
  logic              of;
  logic [15:0]       acc_sat;
  logic [ADDR_W-1:0] base;
  assign base    = {bus.base_addr[ADDR_W-1:1], 1'b0};
  assign sum     = {acc[15], acc} + {bus.red_sum[15], bus.red_sum};
  assign of      = sum[16] ^ sum[15];
  assign acc_sat = of ? (sum[16] ? 16'h8000 : 16'h7fff) : sum[15:0];
  // Outputs are registered, so each transition sets the values seen in the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      cnt          <= '0;
      acc          <= '0;
      bus.mem_addr <= '0;
      bus.mem_ren  <= 1'b0;
      bus.red_a    <= '0;
      bus.red_b    <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.ovfl     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          addr     <= base;
          cnt      <= bus.num_pairs;
          acc      <= '0;
          bus.ovfl <= 1'b0;
          if (bus.num_pairs == '0) begin
            state      <= DONE;
            bus.done   <= 1'b1;
            bus.result <= '0;
          end else begin
            state        <= RD_A;
            bus.busy     <= 1'b1;
            bus.mem_ren  <= 1'b1;
            bus.mem_addr <= base;
          end
        end
        RD_A: begin
          state        <= RD_B;
          bus.mem_addr <= addr + ADDR_W'(2);
        end
        RD_B: begin
          state       <= CAP_B;
          bus.red_a   <= bus.mem_rdata;
          bus.mem_ren <= 1'b0;
        end
        CAP_B: begin
          state     <= ACC;
          bus.red_b <= bus.mem_rdata;
        end
        ACC: begin
          acc      <= acc_sat;
          bus.ovfl <= bus.ovfl | of;
          addr     <= addr + ADDR_W'(4);
          cnt      <= cnt - 1'b1;
          if (cnt == LEN_W'(1)) begin
            state      <= DONE;
            bus.done   <= 1'b1;
            bus.busy   <= 1'b0;
            bus.result <= acc_sat;
          end else begin
            state        <= RD_A;
            bus.mem_ren  <= 1'b1;
            bus.mem_addr <= addr + ADDR_W'(4);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_red_accum_ctrl.sv
// tb_red_accum_ctrl: directed jobs against a memory model and a byte-sum RED model.
module tb_red_accum_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [15:0] mem [0:32767];
  logic [15:0] rd_q[$];
  int lat;
  red_accum_if bus ();
  red_accum_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [15:0] red(input logic [15:0] a, input logic [15:0] b);
    return {{8{a[15]}}, a[15:8]} + {{8{a[7]}}, a[7:0]} + {{8{b[15]}}, b[15:8]} + {{8{b[7]}}, b[7:0]};
  endfunction
  assign bus.red_sum = red(bus.red_a, bus.red_b);
  always_ff @(posedge clk) if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr[15:1]];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [15:0] base, input logic [7:0] n, input int poke);
    @(negedge clk);
    bus.base_addr = base;
    bus.num_pairs = n;
    bus.start = 1'b1;
    rd_q.delete();
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 2000) begin
      if (bus.mem_ren) rd_q.push_back(bus.mem_addr);
      bus.start = (poke != 0 && lat == poke);
      if (bus.start) begin
        bus.base_addr = 16'h2000;
        bus.num_pairs = 8'd5;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
  endtask
  initial begin
    int seen;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[16'h0100 >> 1] = 16'h0102;
    mem[16'h0102 >> 1] = 16'h0304;
    mem[16'h0104 >> 1] = 16'hffff;
    mem[16'h0106 >> 1] = 16'hffff;
    for (int i = 0; i < 400; i++) mem[(16'h1000 >> 1) + i] = 16'h7f7f;
    mem[16'hfffc >> 1] = 16'h0101;
    mem[16'hfffe >> 1] = 16'h0202;
    mem[0] = 16'h0303;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_pairs = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ren", bus.mem_ren, 0);
    chk("rst_ovfl", bus.ovfl, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_result", bus.result, 0);
    rst = 1'b0;
    run(16'h0100, 8'd1, 0);
    chk("p1_lat", lat, 5);
    chk("p1_result", bus.result, 16'h000a);
    chk("p1_ovfl", bus.ovfl, 0);
    chk("p1_nrd", rd_q.size(), 2);
    chk("p1_rd0", rd_q[0], 16'h0100);
    chk("p1_rd1", rd_q[1], 16'h0102);
    run(16'h0100, 8'd2, 0);
    chk("p2_lat", lat, 9);
    chk("p2_result", bus.result, 16'h0006);
    chk("p2_nrd", rd_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("p2_rd%0d", i), rd_q[i], 16'h0100 + 16'(2 * i));
    run(16'h1234, 8'd0, 0);
    chk("p0_lat", lat, 1);
    chk("p0_result", bus.result, 0);
    chk("p0_nrd", rd_q.size(), 0);
    run(16'h1000, 8'd200, 0);
    chk("sat_lat", lat, 801);
    chk("sat_result", bus.result, 16'h7fff);
    chk("sat_ovfl", bus.ovfl, 1);
    @(negedge clk);
    chk("sat_hold", bus.result, 16'h7fff);
    chk("sat_ovfl_hold", bus.ovfl, 1);
    run(16'h0100, 8'd1, 0);
    chk("post_result", bus.result, 16'h000a);
    chk("post_ovfl", bus.ovfl, 0);
    run(16'hfffd, 8'd1, 0);
    chk("odd_result", bus.result, 16'h0006);
    chk("odd_rd0", rd_q[0], 16'hfffc);
    chk("odd_rd1", rd_q[1], 16'hfffe);
    run(16'hfffe, 8'd1, 0);
    chk("wrap_result", bus.result, 16'h000a);
    chk("wrap_rd0", rd_q[0], 16'hfffe);
    chk("wrap_rd1", rd_q[1], 16'h0000);
    run(16'h0100, 8'd2, 3);
    chk("ign_lat", lat, 9);
    chk("ign_result", bus.result, 16'h0006);
    chk("ign_nrd", rd_q.size(), 4);
    chk("ign_rd3", rd_q[3], 16'h0106);
    @(negedge clk);
    bus.base_addr = 16'h0100;
    bus.num_pairs = 8'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("cap_reda", bus.red_a, 16'h0102);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", bus.busy, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_ren", bus.mem_ren, 0);
    chk("mid_addr", bus.mem_addr, 0);
    chk("mid_reda", bus.red_a, 0);
    chk("mid_redb", bus.red_b, 0);
    chk("mid_result", bus.result, 0);
    seen = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1;
    end
    chk("mid_idle", seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
